slow_memory_pro: RTL and testbench

- Parametrised, cycle-counted successor to the team's slow-memory handshake model. It sits behind the I/D caches as backing store and serves one cache line per request.
- Adds the following:
  - latency counted in clock cycles, with separate read and write latency;
  - configurable line and word geometry;
  - a per-word write mask;
  - busy and error status;
  - asynchronous reset.

---
 rtl/slow_memory_pro.sv | 134 +++++++++++++
 tb/tb_slow_memory_pro.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/slow_memory_pro.sv
// Cycle-counted backing store serving one cache line per request, with separate
// read/write latency, per-word write mask, busy and error status.
module slow_memory_pro #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINES  = 256,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned WR_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [WORD_W*WORDS-1:0]  mem_wdata,
  input  logic [WORDS-1:0]         mem_wmask,
  output logic [WORD_W*WORDS-1:0]  mem_rdata,
  output logic                     mem_ready,
  output logic                     mem_busy,
  output logic                     mem_err
);

  localparam int unsigned LINE_W  = WORD_W * WORDS;
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned IDX_W   = ADDR_W + $clog2(WORDS) + 1;
  localparam int unsigned MEM_AW  = (LINES * WORDS > 1) ? $clog2(LINES * WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone, StRecover} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 op_wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_W-1:0]    wdata_q;
  logic [WORDS-1:0]     wmask_q;

  // Input stage: the FSM only ever looks at these registered copies.
  logic                 req_rd_q;
  logic                 req_wr_q;
  logic [ADDR_W-1:0]    in_addr_q;
  logic [LINE_W-1:0]    in_wdata_q;
  logic [WORDS-1:0]     in_wmask_q;

  logic [WORD_W-1:0]    mem [LINES*WORDS];

  logic                 in_range;
  logic [IDX_W-1:0]     base;
  logic [LINE_W-1:0]    line_rd;
  logic                 commit_wr;

  assign in_range  = 64'(addr_q) < 64'(LINES);
  assign base      = IDX_W'(addr_q) * IDX_W'(WORDS);
  assign commit_wr = (state_q == StWait) && (cnt_q == '0) && op_wr_q && in_range;

  // Truncation to MEM_AW is safe: the result is only used when in_range holds.
  always_comb begin
    line_rd = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      line_rd[i*WORD_W +: WORD_W] = mem[MEM_AW'(base + IDX_W'(i))];
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rd_q   <= 1'b0;
      req_wr_q   <= 1'b0;
      in_addr_q  <= '0;
      in_wdata_q <= '0;
      in_wmask_q <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      mem_rdata  <= '0;
      mem_ready  <= 1'b0;
      mem_busy   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      req_rd_q   <= mem_read;
      req_wr_q   <= mem_write;
      in_addr_q  <= mem_addr;
      in_wdata_q <= mem_wdata;
      in_wmask_q <= mem_wmask;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_rd_q ^ req_wr_q) begin
            op_wr_q  <= req_wr_q;
            addr_q   <= in_addr_q;
            wdata_q  <= in_wdata_q;
            wmask_q  <= in_wmask_q;
            cnt_q    <= req_wr_q ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
            mem_busy <= 1'b1;
            state_q  <= StWait;
          end else if (req_rd_q && req_wr_q) begin
            mem_err <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            mem_ready <= 1'b1;
            mem_err   <= !in_range;
            if (!op_wr_q) mem_rdata <= in_range ? line_rd : '0;
            state_q   <= StDone;
          end
        end
        StDone:    state_q <= StRecover;
        StRecover: begin
          mem_busy <= 1'b0;
          state_q  <= StIdle;
        end
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Storage has no reset so benches can preload it; reset forces StIdle, which
  // blocks commit_wr and so abandons any pending write.
  always_ff @(negedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        if (wmask_q[i]) mem[MEM_AW'(base + IDX_W'(i))] <= wdata_q[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: tb/tb_slow_memory_pro.sv
// Randomised scoreboard bench for slow_memory_pro against a line-level array model.
module tb_slow_memory_pro;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINES  = 256;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned WR_LAT = 5;
  localparam int unsigned LINE_W = WORD_W * WORDS;

  logic              clk = 1'b1;
  logic              rst_n = 1'b0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [LINE_W-1:0] mem_wdata = '0;
  logic [WORDS-1:0]  mem_wmask = '0;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_busy;
  logic              mem_err;

  slow_memory_pro #(
    .ADDR_W(ADDR_W), .LINES(LINES), .WORD_W(WORD_W), .WORDS(WORDS),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              rdy;
    logic              err;
    logic [LINE_W-1:0] data;
    int                at;
  } exp_t;

  exp_t              sb[$];
  logic [LINE_W-1:0] model [LINES];
  logic [LINE_W-1:0] last_rdata = '0;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready or error pulse must match the oldest expectation.
  always @(posedge clk) begin
    if (rst_n && (mem_ready || mem_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {mem_ready, mem_err}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready", LINE_W'(mem_ready), LINE_W'(e.rdy));
        check("err", LINE_W'(mem_err), LINE_W'(e.err));
        check("pulse_cycle", LINE_W'(cyc), LINE_W'(e.at));
        check("rdata", mem_rdata, e.data);
      end
    end
  end

  // One request held for a single cycle; the model predicts the response and
  // busy is checked every cycle until the access has fully retired.
  task automatic issue(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] data, input logic [WORDS-1:0] mask);
    exp_t e;
    int   c, lat, a;
    bit   in_rng;
    @(posedge clk);
    c = cyc;
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = data; mem_wmask = mask;
    in_rng = addr < ADDR_W'(LINES);
    a = in_rng ? int'(addr) : 0;
    lat = wr ? WR_LAT : RD_LAT;
    if (rd ^ wr) begin
      if (rd) last_rdata = in_rng ? model[a] : '0;
      else if (in_rng) begin
        for (int i = 0; i < int'(WORDS); i++)
          if (mask[i]) model[a][i*WORD_W +: WORD_W] = data[i*WORD_W +: WORD_W];
      end
      e = '{rdy: 1'b1, err: !in_rng, data: last_rdata, at: c + 1 + lat + 1};
      sb.push_back(e);
    end else if (rd && wr) begin
      e = '{rdy: 1'b0, err: 1'b1, data: last_rdata, at: c + 2};
      sb.push_back(e);
    end
    @(posedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    check("busy_at_sample", LINE_W'(mem_busy), '0);
    if (rd ^ wr) begin
      for (int j = 1; j <= lat + 2; j++) begin
        @(posedge clk);
        check("busy_active", LINE_W'(mem_busy), LINE_W'(1));
      end
      @(posedge clk);
      check("busy_retired", LINE_W'(mem_busy), '0);
    end else begin
      for (int j = 1; j <= 3; j++) begin
        @(posedge clk);
        check("busy_idle", LINE_W'(mem_busy), '0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]        wi;
    logic [LINE_W-1:0] abcd;
    int                bad;
    int                kind;
    logic [ADDR_W-1:0] ra;

    for (int w = 0; w < int'(LINES * WORDS); w++) begin
      wi = 10'(w);
      dut.mem[wi] = $urandom;
    end
    for (int w = 20; w < 24; w++) begin
      wi = 10'(w);
      dut.mem[wi] = 32'((w - 20) * 'h11);
    end
    for (int l = 0; l < int'(LINES); l++)
      for (int i = 0; i < int'(WORDS); i++) begin
        wi = 10'(l * int'(WORDS) + i);
        model[l][i*WORD_W +: WORD_W] = dut.mem[wi];
      end

    #1;
    check("reset_outputs", {mem_rdata, mem_ready, mem_busy, mem_err}, '0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    check("idle_outputs", {mem_rdata, mem_ready, mem_busy, mem_err}, '0);

    issue(1, 0, 28'd5, '0, '0);
    abcd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    issue(0, 1, 28'd7, abcd, 4'b1111);
    issue(1, 0, 28'd7, '0, '0);
    issue(0, 1, 28'd7, '1, 4'b0101);
    issue(1, 0, 28'd7, '0, '0);
    issue(1, 1, 28'd7, '1, 4'b1111);
    issue(1, 0, 28'd7, '0, '0);
    issue(1, 0, 28'd300, '0, '0);
    issue(0, 1, 28'd300, '1, 4'b1111);

    // Reset in the middle of a write's wait phase.
    @(posedge clk);
    mem_write = 1'b1; mem_addr = 28'd9; mem_wdata = {4{32'h5A5A_A5A5}}; mem_wmask = 4'hF;
    @(posedge clk);
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {mem_rdata, mem_ready, mem_busy, mem_err}, '0);
    last_rdata = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    issue(1, 0, 28'd9, '0, '0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      case ($urandom_range(0, 9))
        0:       ra = ADDR_W'($urandom_range(256, 4000));
        1:       ra = '1;
        default: ra = ADDR_W'($urandom_range(0, 15));
      endcase
      if (kind < 5)      issue(1, 0, ra, '0, '0);
      else if (kind < 9) issue(0, 1, ra, {$urandom, $urandom, $urandom, $urandom},
                               4'($urandom_range(0, 15)));
      else               issue(1, 1, ra, '1, 4'hF);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    for (int j = 0; j < 20 && sb.size() != 0; j++) @(posedge clk);
    check("scoreboard_drained", LINE_W'(sb.size()), '0);

    bad = 0;
    for (int l = 0; l < int'(LINES); l++)
      for (int i = 0; i < int'(WORDS); i++) begin
        wi = 10'(l * int'(WORDS) + i);
        if (dut.mem[wi] !== model[l][i*WORD_W +: WORD_W]) bad++;
      end
    check("storage_scan", LINE_W'(bad), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
